shift_operand_decoder: RTL and testbench
========================================

// Module: shift_operand_decoder
// PURPOSE
// Decodes an ARM data-processing operand2 field (I bit + 12 bits) into the control interface of
// barrel_shift_arm (shift_in, shift_amount, shift_op, carry_flag), i.e. the producer/driver side of that
// interface. Sits between register read and the shifter; fetches Rs for register-specified shifts over a
// register-file read handshake; results are held in a valid/ready output register.
// PARAMETERS
// DATA_WIDTH      32  operand/register data width
// ADDR_WIDTH      5   shift_amount width (log2 DATA_WIDTH)
// REG_ADDR_WIDTH  4   register index width (Rs)
// PORTS
// clk             in   1   clock
// rst_n           in   1   reset, synchronous, active-low
// in_valid        in   1   operand2 presented
// in_ready        out  1   decoder accepts this cycle
// i_bit           in   1   1: rotated 8-bit immediate; 0: shifted register
// operand2        in   12  instruction bits [11:0]
// rm_data         in   32  value of Rm, valid with in_valid
// carry_flag      in   1   CPSR C, sampled at accept
// rs_req          out  1   Rs read request (level, held until rs_valid)
// rs_addr         out  4   Rs index = operand2[11:8]
// rs_valid        in   1   rs_data valid
// rs_data         in   32  Rs value
// out_valid       out  1   decoded shift command valid
// out_ready       in   1   shifter stage accepts
// shift_in        out  32  shifter operand
// shift_amount    out  5   shifter amount
// shift_op        out  2   0 LSL, 1 LSR, 2 ASR, 3 ROR
// shift_carry_in  out  1   carry_flag captured at accept
// shift_zero      out  1   effective amount 0: pass-through, carry out = shift_carry_in
// shift_big       out  1   effective amount >= 32 (LSR/ASR/LSL), or ROR by multiple of 32
// shift_rrx       out  1   RRX (ROR #0 immediate form)
// decode_err      out  1   operand2[7]&operand2[4] with i_bit=0 (not a shifter operand)
// BEHAVIOUR
// - Reset: state IDLE; out_valid, rs_req, decode_err, all shift_* outputs 0; rs_addr 0.
// - States: IDLE, RS_WAIT, OUT_HOLD. Accept = in_valid & in_ready.
// - in_ready = (state==IDLE) & (~out_valid | out_ready).
// - i_bit=1: shift_in={24'b0,op2[7:0]}, op=3, amount={op2[11:8],1'b0}, zero=(op2[11:8]==0). 1-cycle latency.
// - i_bit=0, op2[4]=0: shift_in=rm_data, op=op2[6:5], amount=op2[11:7]; if amount==0: LSL->zero=1;
//   LSR/ASR->big=1 (means #32); ROR->rrx=1. 1-cycle latency.
// - i_bit=0, op2[4]=1, op2[7]=0: accept -> RS_WAIT, rs_req=1 and rs_addr from next cycle, held until
//   rs_valid; cycle after rs_valid: out_valid. amount=rs_data[4:0]; zero=(rs_data[7:0]==0);
//   big=(rs_data[7:5]!=0) & (op!=3 | rs_data[4:0]==0); rs_data[31:8] ignored.
// - decode_err case: 1-cycle latency, out_valid=1, decode_err=1, other shift_* outputs 0.
// - Output register holds stable while out_valid & ~out_ready (OUT_HOLD); drops when consumed
//   with no new accept. Back-to-back non-register forms: 1 per cycle with out_ready=1.
// - rs_valid outside RS_WAIT ignored. Exactly one of zero/big/rrx may be 1.
// - Reset mid-operation: next cycle IDLE, rs_req=0, out_valid=0; late rs_valid ignored.
// CONFIGURATION
// SHIFT_DEC_STATS_EN defined: adds output stall_cycles[15:0], counts cycles in RS_WAIT, saturates at
// 16'hFFFF, cleared by reset. Undefined: port and counter absent, function otherwise identical.
// TESTING
// - i_bit=1, op2=12'h4FF -> next cycle out_valid, shift_in=32'h000000FF, op=3, amount=8, zero=0.
// - i_bit=0, op2=12'h202, rm_data=32'h12345678, carry=1 -> shift_in=32'h12345678, op=0, amount=4, carry_in=1.
// - op2=12'h022 -> op=1, big=1; op2=12'h062 -> op=3, rrx=1; op2=12'h002 -> zero=1.
// - op2=12'h332, rs_valid 3 cycles late, rs_data=32'h120 -> rs_addr=3, op=1, amount=0, big=1;
//   rs_data=32'h100 -> zero=1; op2=12'h090 -> decode_err=1.
// - out_ready low 4 cycles: outputs stable, in_ready=0; then 3 immediates back-to-back, 1 per cycle.
// - rst_n low in RS_WAIT -> next cycle rs_req=0, out_valid=0; later rs_valid produces no output.

Source files
------------

// File: rtl/shift_operand_decoder.sv
// shift_operand_decoder
// Turns an ARM data-processing operand2 field (I bit + 12 bits) into the
// control interface of the barrel shifter: operand, amount, op, carry-in and
// the zero/big/rrx special-case flags.
// - Immediate and register-immediate forms decode in one cycle.
// - Register-specified shifts first fetch Rs over a request/valid handshake.
// - Results sit in a valid/ready output register that holds while stalled.
// Optional feature: define SHIFT_DEC_STATS_EN to add the stall_cycles output,
// which counts the cycles spent waiting for Rs and saturates at 16'hFFFF.
module shift_operand_decoder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      i_bit,
    input  logic [11:0]               operand2,
    input  logic [DATA_WIDTH-1:0]     rm_data,
    input  logic                      carry_flag,
    output logic                      rs_req,
    output logic [REG_ADDR_WIDTH-1:0] rs_addr,
    input  logic                      rs_valid,
    input  logic [DATA_WIDTH-1:0]     rs_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     shift_in,
    output logic [ADDR_WIDTH-1:0]     shift_amount,
    output logic [1:0]                shift_op,
    output logic                      shift_carry_in,
    output logic                      shift_zero,
    output logic                      shift_big,
    output logic                      shift_rrx,
`ifdef SHIFT_DEC_STATS_EN
    output logic [15:0]               stall_cycles,
`endif
    output logic                      decode_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RS_WAIT  = 2'd1,
        ST_OUT_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'd0;
    localparam logic [1:0] OP_LSR = 2'd1;
    localparam logic [1:0] OP_ASR = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    // Flags {zero, big, rrx} for a shift by an immediate amount: amount 0 is
    // reinterpreted per op (LSL #0 pass-through, LSR/ASR #0 mean #32, ROR #0 is RRX).
    function automatic logic [2:0] imm_shift_flags(input logic [1:0] op,
                                                   input logic [4:0] amt);
        logic [2:0] flags;
        flags = 3'b000;
        if (amt == 5'd0) begin
            case (op)
                OP_LSL:  flags = 3'b100;
                OP_LSR:  flags = 3'b010;
                OP_ASR:  flags = 3'b010;
                OP_ROR:  flags = 3'b001;
                default: flags = 3'b000;
            endcase
        end else begin
            flags = 3'b000;
        end
        return flags;
    endfunction

    // Flags {zero, big, rrx} for a shift by Rs[7:0]. A ROR by a non-zero
    // multiple of 32 is "big" (result unchanged, carry = bit 31); any other
    // ROR wraps and only uses the low five bits.
    function automatic logic [2:0] reg_shift_flags(input logic [1:0] op,
                                                   input logic [7:0] rs_low);
        logic zero_f;
        logic big_f;
        zero_f = (rs_low == 8'd0);
        big_f  = (rs_low[7:5] != 3'd0) && ((op != OP_ROR) || (rs_low[4:0] == 5'd0));
        return {zero_f, big_f, 1'b0};
    endfunction

    // Registered state
    state_t                    state_q, state_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     shift_in_q, shift_in_d;
    logic [ADDR_WIDTH-1:0]     shift_amount_q, shift_amount_d;
    logic [1:0]                shift_op_q, shift_op_d;
    logic                      shift_carry_in_q, shift_carry_in_d;
    logic                      shift_zero_q, shift_zero_d;
    logic                      shift_big_q, shift_big_d;
    logic                      shift_rrx_q, shift_rrx_d;
    logic                      decode_err_q, decode_err_d;
    logic                      rs_req_q, rs_req_d;
    logic [REG_ADDR_WIDTH-1:0] rs_addr_q, rs_addr_d;
    logic [DATA_WIDTH-1:0]     pend_rm_q, pend_rm_d;
    logic [1:0]                pend_op_q, pend_op_d;
    logic                      pend_carry_q, pend_carry_d;

    // Combinational decode of the presented operand
    logic                      in_ready_s;
    logic                      accept_s;
    logic                      is_rs_form_s;
    logic                      is_err_form_s;
    logic [DATA_WIDTH-1:0]     dec_shift_in_s;
    logic [ADDR_WIDTH-1:0]     dec_amount_s;
    logic [1:0]                dec_op_s;
    logic                      dec_carry_s;
    logic [2:0]                dec_flags_s;
    logic                      dec_err_s;
    logic [2:0]                rs_flags_s;
    logic                      unused_rs_hi_s;

    // The shifter only consumes Rs[7:0]; the upper bits are intentionally dropped.
    assign unused_rs_hi_s = ^rs_data[DATA_WIDTH-1:8];

    assign is_err_form_s = ~i_bit & operand2[7] & operand2[4];
    assign is_rs_form_s  = ~i_bit & ~operand2[7] & operand2[4];
    assign accept_s      = in_valid & in_ready_s;
    assign rs_flags_s    = reg_shift_flags(pend_op_q, rs_data[7:0]);

    // State register and all datapath flops, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            out_valid_q      <= 1'b0;
            shift_in_q       <= {DATA_WIDTH{1'b0}};
            shift_amount_q   <= {ADDR_WIDTH{1'b0}};
            shift_op_q       <= 2'd0;
            shift_carry_in_q <= 1'b0;
            shift_zero_q     <= 1'b0;
            shift_big_q      <= 1'b0;
            shift_rrx_q      <= 1'b0;
            decode_err_q     <= 1'b0;
            rs_req_q         <= 1'b0;
            rs_addr_q        <= {REG_ADDR_WIDTH{1'b0}};
            pend_rm_q        <= {DATA_WIDTH{1'b0}};
            pend_op_q        <= 2'd0;
            pend_carry_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            out_valid_q      <= out_valid_d;
            shift_in_q       <= shift_in_d;
            shift_amount_q   <= shift_amount_d;
            shift_op_q       <= shift_op_d;
            shift_carry_in_q <= shift_carry_in_d;
            shift_zero_q     <= shift_zero_d;
            shift_big_q      <= shift_big_d;
            shift_rrx_q      <= shift_rrx_d;
            decode_err_q     <= decode_err_d;
            rs_req_q         <= rs_req_d;
            rs_addr_q        <= rs_addr_d;
            pend_rm_q        <= pend_rm_d;
            pend_op_q        <= pend_op_d;
            pend_carry_q     <= pend_carry_d;
        end
    end

    // Next-state logic: Rs fetch waits in RS_WAIT, a stalled output parks in OUT_HOLD
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_rs_form_s) begin
                    state_d = ST_RS_WAIT;
                end else if (out_valid_q && !out_ready) begin
                    state_d = ST_OUT_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RS_WAIT: begin
                if (rs_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RS_WAIT;
                end
            end
            ST_OUT_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output-side handshake: accept only when idle and the output slot frees this cycle
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_IDLE:     in_ready_s = ~out_valid_q | out_ready;
            ST_RS_WAIT:  in_ready_s = 1'b0;
            ST_OUT_HOLD: in_ready_s = 1'b0;
            default:     in_ready_s = 1'b0;
        endcase
    end

    // Single-cycle decode of immediate, register-immediate and illegal forms
    always_comb begin
        dec_shift_in_s = {DATA_WIDTH{1'b0}};
        dec_amount_s   = {ADDR_WIDTH{1'b0}};
        dec_op_s       = 2'd0;
        dec_carry_s    = 1'b0;
        dec_flags_s    = 3'b000;
        dec_err_s      = 1'b0;
        if (i_bit) begin
            // 8-bit immediate rotated right by twice the 4-bit field; never >= 32
            dec_shift_in_s = {{(DATA_WIDTH-8){1'b0}}, operand2[7:0]};
            dec_amount_s   = {operand2[11:8], 1'b0};
            dec_op_s       = OP_ROR;
            dec_carry_s    = carry_flag;
            dec_flags_s    = {(operand2[11:8] == 4'd0), 1'b0, 1'b0};
        end else if (is_err_form_s) begin
            dec_err_s      = 1'b1;
        end else begin
            dec_shift_in_s = rm_data;
            dec_amount_s   = operand2[11:7];
            dec_op_s       = operand2[6:5];
            dec_carry_s    = carry_flag;
            dec_flags_s    = imm_shift_flags(operand2[6:5], operand2[11:7]);
        end
    end

    // Output register and Rs-fetch bookkeeping
    always_comb begin
        out_valid_d      = out_valid_q;
        shift_in_d       = shift_in_q;
        shift_amount_d   = shift_amount_q;
        shift_op_d       = shift_op_q;
        shift_carry_in_d = shift_carry_in_q;
        shift_zero_d     = shift_zero_q;
        shift_big_d      = shift_big_q;
        shift_rrx_d      = shift_rrx_q;
        decode_err_d     = decode_err_q;
        rs_req_d         = rs_req_q;
        rs_addr_d        = rs_addr_q;
        pend_rm_d        = pend_rm_q;
        pend_op_d        = pend_op_q;
        pend_carry_d     = pend_carry_q;

        if (state_q == ST_RS_WAIT) begin
            // The output slot was freed at accept, so it is empty here
            if (rs_valid) begin
                out_valid_d      = 1'b1;
                shift_in_d       = pend_rm_q;
                shift_amount_d   = rs_data[ADDR_WIDTH-1:0];
                shift_op_d       = pend_op_q;
                shift_carry_in_d = pend_carry_q;
                shift_zero_d     = rs_flags_s[2];
                shift_big_d      = rs_flags_s[1];
                shift_rrx_d      = rs_flags_s[0];
                decode_err_d     = 1'b0;
                rs_req_d         = 1'b0;
            end else begin
                rs_req_d         = 1'b1;
            end
        end else if (accept_s && !is_rs_form_s) begin
            out_valid_d      = 1'b1;
            shift_in_d       = dec_shift_in_s;
            shift_amount_d   = dec_amount_s;
            shift_op_d       = dec_op_s;
            shift_carry_in_d = dec_carry_s;
            shift_zero_d     = dec_flags_s[2];
            shift_big_d      = dec_flags_s[1];
            shift_rrx_d      = dec_flags_s[0];
            decode_err_d     = dec_err_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d      = 1'b0;
        end else begin
            out_valid_d      = out_valid_q;
        end

        // Register-specified shift: latch what is needed until Rs arrives
        if (accept_s && is_rs_form_s) begin
            rs_req_d     = 1'b1;
            rs_addr_d    = operand2[11:8];
            pend_rm_d    = rm_data;
            pend_op_d    = operand2[6:5];
            pend_carry_d = carry_flag;
        end else begin
            pend_rm_d    = pend_rm_q;
        end
    end

    // Drive ports from registers; in_ready is the combinational handshake term
    always_comb begin
        in_ready       = in_ready_s;
        out_valid      = out_valid_q;
        shift_in       = shift_in_q;
        shift_amount   = shift_amount_q;
        shift_op       = shift_op_q;
        shift_carry_in = shift_carry_in_q;
        shift_zero     = shift_zero_q;
        shift_big      = shift_big_q;
        shift_rrx      = shift_rrx_q;
        decode_err     = decode_err_q;
        rs_req         = rs_req_q;
        rs_addr        = rs_addr_q;
    end

`ifdef SHIFT_DEC_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of cycles spent waiting on the register file for Rs
    always_comb begin
        if ((state_q == ST_RS_WAIT) && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_shift_operand_decoder.sv
// Directed testbench for shift_operand_decoder. Inputs change and outputs are
// sampled on the falling clock edge; expected values are hand-computed.
module tb_shift_operand_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        i_bit;
    logic [11:0] operand2;
    logic [31:0] rm_data;
    logic        carry_flag;
    logic        rs_req;
    logic [3:0]  rs_addr;
    logic        rs_valid;
    logic [31:0] rs_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] shift_in;
    logic [4:0]  shift_amount;
    logic [1:0]  shift_op;
    logic        shift_carry_in;
    logic        shift_zero;
    logic        shift_big;
    logic        shift_rrx;
    logic        decode_err;

    int total_cnt;
    int bad_cnt;

    shift_operand_decoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .i_bit          (i_bit),
        .operand2       (operand2),
        .rm_data        (rm_data),
        .carry_flag     (carry_flag),
        .rs_req         (rs_req),
        .rs_addr        (rs_addr),
        .rs_valid       (rs_valid),
        .rs_data        (rs_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .shift_in       (shift_in),
        .shift_amount   (shift_amount),
        .shift_op       (shift_op),
        .shift_carry_in (shift_carry_in),
        .shift_zero     (shift_zero),
        .shift_big      (shift_big),
        .shift_rrx      (shift_rrx),
        .decode_err     (decode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the full output command against expected values
    task automatic chk_out(input string tag, input logic v, input logic [31:0] sin,
                           input logic [4:0] amt, input logic [1:0] op, input logic cin,
                           input logic z, input logic b, input logic r, input logic err);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, "_in"},    shift_in, sin);
        chk({tag, "_amt"},   {27'd0, shift_amount}, {27'd0, amt});
        chk({tag, "_op"},    {30'd0, shift_op}, {30'd0, op});
        chk({tag, "_cin"},   {31'd0, shift_carry_in}, {31'd0, cin});
        chk({tag, "_flags"}, {28'd0, shift_zero, shift_big, shift_rrx, decode_err},
                             {28'd0, z, b, r, err});
    endtask

    // Present one operand for a single cycle (called at a falling edge)
    task automatic drive_op(input string tag, input logic ib, input logic [11:0] op2,
                            input logic [31:0] rm, input logic c);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        i_bit      = ib;
        operand2   = op2;
        rm_data    = rm;
        carry_flag = c;
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    // Register-specified shift: accept, wait `lat` extra cycles, then return Rs
    task automatic rs_op(input string tag, input logic [11:0] op2, input logic [31:0] rm,
                         input logic c, input int lat, input logic [31:0] rsd);
        drive_op(tag, 1'b0, op2, rm, c);
        chk({tag, "_req"},  {31'd0, rs_req}, 32'd1);
        chk({tag, "_addr"}, {28'd0, rs_addr}, {28'd0, op2[11:8]});
        chk({tag, "_wait"}, {30'd0, out_valid, in_ready}, 32'd0);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {30'd0, rs_req, out_valid}, 32'd2);
        end
        rs_valid = 1'b1;
        rs_data  = rsd;
        @(negedge clk);
        rs_valid = 1'b0;
        rs_data  = 32'hDEAD_BEEF;
        chk({tag, "_reqdn"}, {31'd0, rs_req}, 32'd0);
    endtask

    initial begin
        total_cnt  = 0;
        bad_cnt    = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        i_bit      = 1'b0;
        operand2   = 12'd0;
        rm_data    = 32'd0;
        carry_flag = 1'b0;
        rs_valid   = 1'b0;
        rs_data    = 32'd0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk_out("rst", 1'b0, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_req",  {31'd0, rs_req}, 32'd0);
        chk("rst_addr", {28'd0, rs_addr}, 32'd0);
        chk("rst_rdy",  {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Rotated immediate
        drive_op("imm", 1'b1, 12'h4FF, 32'hFFFF_FFFF, 1'b0);
        chk_out("imm", 1'b1, 32'h0000_00FF, 5'd8, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Register shifted by immediate
        drive_op("lsl4", 1'b0, 12'h202, 32'h1234_5678, 1'b1);
        chk_out("lsl4", 1'b1, 32'h1234_5678, 5'd4, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_op("lsr32", 1'b0, 12'h022, 32'h8000_0001, 1'b0);
        chk_out("lsr32", 1'b1, 32'h8000_0001, 5'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_op("rrx", 1'b0, 12'h062, 32'h0000_0003, 1'b1);
        chk_out("rrx", 1'b1, 32'h0000_0003, 5'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_op("lsl0", 1'b0, 12'h002, 32'hA5A5_A5A5, 1'b0);
        chk_out("lsl0", 1'b1, 32'hA5A5_A5A5, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Illegal form: flagged, all shift fields cleared
        drive_op("err", 1'b0, 12'h090, 32'h5555_5555, 1'b1);
        chk_out("err", 1'b1, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("drain", {31'd0, out_valid}, 32'd0);

        // Register-specified shifts
        rs_op("rs_big", 12'h332, 32'hCAFE_0001, 1'b1, 2, 32'h0000_0120);
        chk_out("rs_big", 1'b1, 32'hCAFE_0001, 5'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rs_op("rs_zero", 12'h332, 32'h0000_0F0F, 1'b0, 0, 32'hFFFF_FF00);
        chk_out("rs_zero", 1'b1, 32'h0000_0F0F, 5'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rs_op("rs_ror64", 12'h570, 32'h1111_2222, 1'b0, 1, 32'h0000_0040);
        chk_out("rs_ror64", 1'b1, 32'h1111_2222, 5'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rs_op("rs_ror36", 12'h570, 32'h3333_4444, 1'b1, 0, 32'h0000_0024);
        chk_out("rs_ror36", 1'b1, 32'h3333_4444, 5'd4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Output stall: held stable, competing request not taken
        out_ready = 1'b0;
        drive_op("stall", 1'b1, 12'h1AB, 32'd0, 1'b0);
        in_valid = 1'b1;
        i_bit    = 1'b1;
        operand2 = 12'h4FF;
        for (int k = 0; k < 4; k++) begin
            chk_out("stall", 1'b1, 32'h0000_00AB, 5'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("stall_rdy", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release", {31'd0, out_valid, in_ready}, 32'd1);

        // Three immediates back-to-back, one per cycle
        drive_op("b2b0", 1'b1, 12'h101, 32'd0, 1'b0);
        chk_out("b2b0", 1'b1, 32'h0000_0001, 5'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_op("b2b1", 1'b1, 12'h202, 32'd0, 1'b1);
        chk_out("b2b1", 1'b1, 32'h0000_0002, 5'd4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_op("b2b2", 1'b1, 12'h303, 32'd0, 1'b0);
        chk_out("b2b2", 1'b1, 32'h0000_0003, 5'd6, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_drain", {31'd0, out_valid}, 32'd0);

        // Reset while waiting for Rs; a late rs_valid must be ignored
        drive_op("mrst", 1'b0, 12'h332, 32'h7777_7777, 1'b1);
        chk("mrst_req", {31'd0, rs_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_now", {30'd0, rs_req, out_valid}, 32'd0);
        rst_n    = 1'b1;
        rs_valid = 1'b1;
        rs_data  = 32'h0000_0004;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("mrst_late", {30'd0, rs_req, out_valid}, 32'd0);
        end
        rs_valid = 1'b0;
        chk("mrst_rdy", {31'd0, in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
